visor_breakpoint_unit: RTL and testbench

VISOR_BREAKPOINT_UNIT -- requirements
Module: visor_breakpoint_unit

---
 rtl/visor_bp_pkg.sv | 26 ++
 rtl/visor_bp_channel.sv | 101 ++++++++++
 rtl/visor_breakpoint_unit.sv | 115 +++++++++++
 tb/tb_visor_breakpoint_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/visor_bp_pkg.sv
// Shared encodings for the visor breakpoint unit: channel modes, config
// register selects, hit-source codes and the pass-counter width.
package visor_bp_pkg;

    // Channel match mode held in CTRL[1:0]; 3 is reserved and behaves as OFF.
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_EXACT = 2'd1;
    localparam logic [1:0] MODE_RANGE = 2'd2;

    // cfg_reg selects; 3 is reserved and writes nothing.
    localparam logic [1:0] REG_LO   = 2'd0;
    localparam logic [1:0] REG_HI   = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    // Cause of the captured hit.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CHAN = 2'd1,
        SRC_STEP = 2'd2,
        SRC_PBRK = 2'd3
    } hit_src_e;

    // Width of the per-channel pass counter and of CTRL[15:8].
    localparam int BP_CNT_W = 8;

endpackage

// File: rtl/visor_bp_channel.sv
// One breakpoint channel: LO/HI/CTRL storage, combinational address
// comparator, sticky pending flag and (with BP_HIT_COUNT_EN) a pass counter.
// hit_o means "this channel qualifies and is allowed to hit this cycle".
module visor_bp_channel
    import visor_bp_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  exec_i,
    input  logic                  clr_i,
    input  logic                  frozen_i,
    input  logic                  we_i,
    input  logic [1:0]            reg_i,
    input  logic [15:0]           data_i,
    output logic                  hit_o
);

    logic [ADDR_WIDTH-1:0] lo_q, hi_q;
    logic [1:0]            mode_q;
    logic                  pend_q, pend_d;
    logic                  match, qual, consume;

    // Address comparator; an inverted range (HI < LO) simply never matches.
    always_comb begin
        match = 1'b0;
        case (mode_q)
            MODE_EXACT: match = (addr_i == lo_q);
            MODE_RANGE: match = (addr_i >= lo_q) && (addr_i <= hi_q);
            default:    match = 1'b0;
        endcase
    end

    assign qual    = exec_i & (pend_q | match);
    // A qualification is only acted on (hit or counted) while no hit is held.
    assign consume = qual & ~frozen_i;

`ifdef BP_HIT_COUNT_EN
    logic [BP_CNT_W-1:0] lim_q, cnt_q;
    logic                below;

    assign below = (cnt_q < lim_q);
    assign hit_o = qual & ~below;

    // Pass counter: restarts when the channel is re-aimed (LO or CTRL write).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (we_i && (reg_i == REG_LO || reg_i == REG_CTRL))
            cnt_q <= '0;
        else if (consume && below && !clr_i)
            cnt_q <= cnt_q + 1'b1;
    end

    // Pass-count limit from CTRL[15:8].
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            lim_q <= '0;
        else if (we_i && reg_i == REG_CTRL)
            lim_q <= data_i[15:8];
    end
`else
    assign hit_o = qual;
`endif

    // Configuration registers; reserved register select writes nothing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lo_q   <= '0;
            hi_q   <= '0;
            mode_q <= MODE_OFF;
        end else if (we_i) begin
            case (reg_i)
                REG_LO:   lo_q   <= data_i[ADDR_WIDTH-1:0];
                REG_HI:   hi_q   <= data_i[ADDR_WIDTH-1:0];
                REG_CTRL: mode_q <= data_i[1:0];
                default:  ;
            endcase
        end
    end

    // Pending: set by a match, dropped when consumed by a qualification or cleared.
    always_comb begin
        pend_d = pend_q | match;
        if (clr_i)
            pend_d = 1'b0;
        else if (consume)
            pend_d = 1'b0;
    end

    // Pending flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            pend_q <= 1'b0;
        else
            pend_q <= pend_d;
    end

endmodule

// File: rtl/visor_breakpoint_unit.sv
// Visor breakpoint unit top: NUM_BP address channels plus step and software
// break sources, qualified on target assignment cycles (enable_exec) into a
// sticky bp_hit with cause mask and source. Define BP_HIT_COUNT_EN to add
// per-channel pass counting.
module visor_breakpoint_unit
    import visor_bp_pkg::*;
#(
    parameter int NUM_BP     = 4,
    parameter int ADDR_WIDTH = 16,
    localparam int SEL_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                  sysclk,
    input  logic                  sysreset_n,
    input  logic [ADDR_WIDTH-1:0] code_addr,
    input  logic                  enable_exec,
    input  logic                  step,
    input  logic                  program_break,
    input  logic                  cfg_wr,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [1:0]            cfg_reg,
    input  logic [15:0]           cfg_data,
    input  logic                  hit_clear,
    output logic                  bp_hit,
    output logic [NUM_BP-1:0]     hit_mask,
    output logic [1:0]            hit_src
);

    logic              clr;
    logic [NUM_BP-1:0] ch_hit;
    logic              step_pend_q, step_pend_d;
    logic              pbrk_pend_q, pbrk_pend_d;
    logic              step_qual, pbrk_qual, any_qual;
    logic              bp_hit_q, bp_hit_d;
    logic [NUM_BP-1:0] hit_mask_q, hit_mask_d;
    hit_src_e          hit_src_q, hit_src_d;

    // Any config write (even to an out-of-range channel) clears hit state.
    assign clr = hit_clear | cfg_wr;

    // Channel array; an out-of-range cfg_sel selects no channel.
    for (genvar i = 0; i < NUM_BP; i++) begin : g_ch
        visor_bp_channel #(.ADDR_WIDTH(ADDR_WIDTH)) u_ch (
            .clk_i    (sysclk),
            .rst_ni   (sysreset_n),
            .addr_i   (code_addr),
            .exec_i   (enable_exec),
            .clr_i    (clr),
            .frozen_i (bp_hit_q),
            .we_i     (cfg_wr && (cfg_sel == SEL_W'(i))),
            .reg_i    (cfg_reg),
            .data_i   (cfg_data),
            .hit_o    (ch_hit[i])
        );
    end

    assign step_qual = enable_exec & (step_pend_q | step);
    assign pbrk_qual = enable_exec & (pbrk_pend_q | program_break);
    assign any_qual  = (|ch_hit) | step_qual | pbrk_qual;

    // Hit capture with priority program_break > step > channel; frozen while held.
    always_comb begin
        bp_hit_d   = bp_hit_q;
        hit_mask_d = hit_mask_q;
        hit_src_d  = hit_src_q;
        if (clr) begin
            bp_hit_d   = 1'b0;
            hit_mask_d = '0;
            hit_src_d  = SRC_NONE;
        end else if (!bp_hit_q && any_qual) begin
            bp_hit_d   = 1'b1;
            hit_mask_d = ch_hit;
            if (pbrk_qual)
                hit_src_d = SRC_PBRK;
            else if (step_qual)
                hit_src_d = SRC_STEP;
            else
                hit_src_d = SRC_CHAN;
        end
    end

    // Step / software-break pending flags, same sticky rules as channels.
    always_comb begin
        step_pend_d = step_pend_q | step;
        pbrk_pend_d = pbrk_pend_q | program_break;
        if (clr) begin
            step_pend_d = 1'b0;
            pbrk_pend_d = 1'b0;
        end else begin
            if (!bp_hit_q && step_qual) step_pend_d = 1'b0;
            if (!bp_hit_q && pbrk_qual) pbrk_pend_d = 1'b0;
        end
    end

    // Hit and pending state registers.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            bp_hit_q    <= 1'b0;
            hit_mask_q  <= '0;
            hit_src_q   <= SRC_NONE;
            step_pend_q <= 1'b0;
            pbrk_pend_q <= 1'b0;
        end else begin
            bp_hit_q    <= bp_hit_d;
            hit_mask_q  <= hit_mask_d;
            hit_src_q   <= hit_src_d;
            step_pend_q <= step_pend_d;
            pbrk_pend_q <= pbrk_pend_d;
        end
    end

    assign bp_hit   = bp_hit_q;
    assign hit_mask = hit_mask_q;
    assign hit_src  = hit_src_q;

endmodule

// File: tb/tb_visor_breakpoint_unit.sv
// Scoreboard bench for visor_breakpoint_unit: every driven cycle pushes the
// reference model's expected outputs; a monitor pops and compares after each
// edge. Directed scenarios add explicit constant checks, then random traffic.
module tb_visor_breakpoint_unit;

    localparam int NB = 4;

    logic        sysclk = 1'b0;
    logic        sysreset_n = 1'b0;
    logic [15:0] code_addr = 16'hF000;
    logic        enable_exec = 1'b0, step = 1'b0, program_break = 1'b0;
    logic        cfg_wr = 1'b0, hit_clear = 1'b0;
    logic [1:0]  cfg_sel = '0, cfg_reg = '0;
    logic [15:0] cfg_data = '0;
    logic        bp_hit;
    logic [NB-1:0] hit_mask;
    logic [1:0]  hit_src;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic          hit;
        logic [NB-1:0] mask;
        logic [1:0]    src;
    } exp_t;
    exp_t sb[$];

    // Reference model state.
    logic [15:0] m_lo[NB], m_hi[NB];
    int          m_mode[NB], m_lim[NB], m_cnt[NB];
    bit          m_pend[NB];
    bit          m_sp, m_pp, m_hit;
    logic [NB-1:0] m_mask;
    logic [1:0]  m_src;

    visor_breakpoint_unit #(.NUM_BP(NB), .ADDR_WIDTH(16)) dut (
        .sysclk(sysclk), .sysreset_n(sysreset_n), .code_addr(code_addr),
        .enable_exec(enable_exec), .step(step), .program_break(program_break),
        .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_reg(cfg_reg), .cfg_data(cfg_data),
        .hit_clear(hit_clear), .bp_hit(bp_hit), .hit_mask(hit_mask), .hit_src(hit_src)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic bit addr_hits(input int i, input logic [15:0] a);
        if (m_mode[i] == 1) return a == m_lo[i];
        if (m_mode[i] == 2) return (a >= m_lo[i]) && (a <= m_hi[i]);
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_lo[i] = '0; m_hi[i] = '0; m_mode[i] = 0; m_lim[i] = 0;
            m_cnt[i] = 0; m_pend[i] = 0;
        end
        m_sp = 0; m_pp = 0; m_hit = 0; m_mask = '0; m_src = 2'd0;
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        bit clr, was_hit, sq, pq;
        bit [NB-1:0] mt, qv, fire, cnt_evt;
        exp_t e;
        clr = hit_clear | cfg_wr;
        was_hit = m_hit;
        mt = '0; qv = '0; fire = '0; cnt_evt = '0;
        for (int i = 0; i < NB; i++) begin
            mt[i] = addr_hits(i, code_addr);
            qv[i] = enable_exec && (m_pend[i] || mt[i]);
`ifdef BP_HIT_COUNT_EN
            if (qv[i] && m_cnt[i] < m_lim[i]) cnt_evt[i] = 1'b1;
            else if (qv[i]) fire[i] = 1'b1;
`else
            fire[i] = qv[i];
`endif
        end
        sq = enable_exec && (m_sp || step);
        pq = enable_exec && (m_pp || program_break);
        if (clr) begin
            m_hit = 0; m_mask = '0; m_src = 2'd0;
        end else if (!was_hit && (fire != '0 || sq || pq)) begin
            m_hit = 1; m_mask = fire;
            m_src = pq ? 2'd3 : (sq ? 2'd2 : 2'd1);
        end
        for (int i = 0; i < NB; i++) begin
            if (clr) m_pend[i] = 0;
            else if (!was_hit && qv[i]) m_pend[i] = 0;
            else m_pend[i] = m_pend[i] | mt[i];
            if (cfg_wr && cfg_sel == i && (cfg_reg == 0 || cfg_reg == 2)) m_cnt[i] = 0;
            else if (!clr && !was_hit && cnt_evt[i]) m_cnt[i]++;
        end
        if (clr) begin m_sp = 0; m_pp = 0; end
        else begin
            m_sp = (!was_hit && sq) ? 1'b0 : (m_sp | step);
            m_pp = (!was_hit && pq) ? 1'b0 : (m_pp | program_break);
        end
        if (cfg_wr) begin
            case (cfg_reg)
                2'd0: m_lo[cfg_sel] = cfg_data;
                2'd1: m_hi[cfg_sel] = cfg_data;
                2'd2: begin m_mode[cfg_sel] = cfg_data[1:0]; m_lim[cfg_sel] = cfg_data[15:8]; end
                default: ;
            endcase
        end
        e.hit = m_hit; e.mask = m_mask; e.src = m_src;
        sb.push_back(e);
    endtask

    // One cycle: model consumes the driven inputs, then wait past the edge.
    task automatic tick();
        model_step();
        @(posedge sysclk);
        #2;
    endtask

    task automatic cfg(input int sel, input int rg, input int data);
        cfg_wr = 1'b1; cfg_sel = sel[1:0]; cfg_reg = rg[1:0]; cfg_data = data[15:0];
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic clear_hit();
        hit_clear = 1'b1; tick(); hit_clear = 1'b0;
    endtask

    task automatic exec_at(input logic [15:0] a);
        code_addr = a; enable_exec = 1'b1; tick();
        enable_exec = 1'b0; code_addr = 16'hF000;
    endtask

    // Monitor: compare DUT against the scoreboard after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge sysclk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (bp_hit !== e.hit || hit_mask !== e.mask || hit_src !== e.src) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t: got hit=%b mask=%b src=%0d want hit=%b mask=%b src=%0d",
                             $time, bp_hit, hit_mask, hit_src, e.hit, e.mask, e.src);
                end
            end
        end
    end

    initial begin
        model_reset();
        #3;
        chk("reset_hit", {31'd0, bp_hit}, 32'd0);
        chk("reset_mask", {28'd0, hit_mask}, 32'd0);
        chk("reset_src", {30'd0, hit_src}, 32'd0);
        #9 sysreset_n = 1'b1;
        @(posedge sysclk); #2;

        // EXACT hit: match one cycle, enable_exec the next.
        cfg(0, 0, 'h0040); cfg(0, 2, 'h0001);
        code_addr = 16'h0040; tick(); code_addr = 16'hF000;
        exec_at(16'hF000);
        chk("exact_hit", {31'd0, bp_hit}, 32'd1);
        chk("exact_mask", {28'd0, hit_mask}, 32'h1);
        chk("exact_src", {30'd0, hit_src}, 32'd1);
        clear_hit();

        // RANGE bounds.
        cfg(1, 0, 'h0100); cfg(1, 1, 'h01FF); cfg(1, 2, 'h0002);
        exec_at(16'h00FF); chk("range_below", {31'd0, bp_hit}, 32'd0);
        exec_at(16'h0200); chk("range_above", {31'd0, bp_hit}, 32'd0);
        exec_at(16'h01FF);
        chk("range_top", {31'd0, bp_hit}, 32'd1);
        chk("range_mask", {28'd0, hit_mask}, 32'h2);
        clear_hit();
        cfg(1, 0, 'h0200); cfg(1, 1, 'h0100);
        exec_at(16'h0100); exec_at(16'h0150); exec_at(16'h0200);
        chk("range_inverted", {31'd0, bp_hit}, 32'd0);

        // Clear race, then cfg write to ch3 drops a held hit.
        code_addr = 16'h0040; tick(); code_addr = 16'hF000;
        hit_clear = 1'b1; enable_exec = 1'b1; tick(); hit_clear = 1'b0;
        chk("clear_race", {31'd0, bp_hit}, 32'd0);
        tick(); enable_exec = 1'b0;
        chk("clear_kills_pending", {31'd0, bp_hit}, 32'd0);
        exec_at(16'h0040); chk("rehit", {31'd0, bp_hit}, 32'd1);
        cfg(3, 2, 'h0000); chk("cfg_clears", {31'd0, bp_hit}, 32'd0);

        // Step priority over channel, program_break over step.
        cfg(2, 0, 'h0080); cfg(2, 2, 'h0001);
        step = 1'b1; code_addr = 16'h0080; tick(); step = 1'b0; code_addr = 16'hF000;
        exec_at(16'hF000);
        chk("step_src", {30'd0, hit_src}, 32'd2);
        chk("step_mask", {28'd0, hit_mask}, 32'h4);
        clear_hit();
        step = 1'b1; program_break = 1'b1; exec_at(16'h0080);
        step = 1'b0; program_break = 1'b0;
        chk("pbrk_src", {30'd0, hit_src}, 32'd3);
        chk("pbrk_mask", {28'd0, hit_mask}, 32'h4);
        clear_hit();

        // Pass count on ch0 (count=2).
        cfg(0, 2, 'h0201);
        for (int k = 0; k < 3; k++) begin
            exec_at(16'h0040);
`ifdef BP_HIT_COUNT_EN
            chk($sformatf("pass_%0d", k), {31'd0, bp_hit}, (k == 2) ? 32'd1 : 32'd0);
`else
            chk($sformatf("pass_%0d", k), {31'd0, bp_hit}, 32'd1);
`endif
            clear_hit();
        end

        // Async reset mid-cycle while a hit is held.
        exec_at(16'h0040);
        chk("pre_reset_hit", {31'd0, bp_hit}, 32'd1);
        sysreset_n = 1'b0; #1;
        chk("async_hit", {31'd0, bp_hit}, 32'd0);
        chk("async_mask", {28'd0, hit_mask}, 32'h0);
        chk("async_src", {30'd0, hit_src}, 32'd0);
        model_reset();
        #1 sysreset_n = 1'b1;
        exec_at(16'h0040);
        chk("post_reset_nomatch", {31'd0, bp_hit}, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            code_addr     = 16'($urandom_range(0, 15));
            enable_exec   = ($urandom_range(0, 2) == 0);
            step          = ($urandom_range(0, 19) == 0);
            program_break = ($urandom_range(0, 29) == 0);
            hit_clear     = ($urandom_range(0, 11) == 0);
            cfg_wr        = ($urandom_range(0, 13) == 0);
            cfg_sel       = 2'($urandom_range(0, 3));
            cfg_reg       = 2'($urandom_range(0, 3));
            if (cfg_reg == 2'd2)
                cfg_data = 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 3));
            else
                cfg_data = 16'($urandom_range(0, 15));
            tick();
        end
        cfg_wr = 1'b0; hit_clear = 1'b0; enable_exec = 1'b0;
        step = 1'b0; program_break = 1'b0;
        tick();
        #2;
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
